// File: rtl/divisibility_pkg.sv
// Shared types and helpers for the serial divisibility datapath.
// Contents: FSM state encoding and the remainder-width helper.
// No ports; imported by serial_mod_tracker and serial_divisibility_word_checker.
package divisibility_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits needed to hold any remainder modulo the given divisor.
    function automatic int rem_width(input int divisor);
        return $clog2(divisor);
    endfunction

endpackage

// File: rtl/serial_mod_tracker.sv
// Serial remainder tracker: folds one MSB-first bit per step into rem mod DIVISOR.
// Latency: rem reflects a bit one cycle after step; clear and rst zero rem.
// Backpressure: none; the caller decides when to step.
// Ports: clk, rst (sync, active-high), clear, step, bit_in -> rem[RW-1:0].
module serial_mod_tracker
    import divisibility_pkg::*;
#(
    parameter  int DIVISOR = 5,
    localparam int RW      = rem_width(DIVISOR)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          step,
    input  logic          bit_in,
    output logic [RW-1:0] rem
);

    localparam logic [RW:0] DIV_T = (RW + 1)'(DIVISOR);

    logic [RW:0]   t;
    logic [RW:0]   diff;
    logic [RW-1:0] rem_next;

    // 2*rem + bit is at most 2*DIVISOR-1, so RW+1 bits always suffice and a
    // single conditional subtract brings it back into range.
    always_comb begin
        t    = {rem, bit_in};
        diff = t;
        if (t >= DIV_T) begin
            diff = t - DIV_T;
        end
        rem_next = diff[RW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
        end else if (clear) begin
            rem <= '0;
        end else if (step) begin
            rem <= rem_next;
        end
    end

endmodule

// File: rtl/serial_divisibility_word_checker.sv
// Word-level divisibility checker: accepts a W-bit word, streams it MSB-first
// through serial_mod_tracker, then presents word, remainder and divisible flag.
// Latency: out_valid rises W cycles after the accept edge; W+2 cycles per word best case.
// Backpressure: result held stable in DONE until out_ready; in_ready low from accept to release.
// Ports: clk, rst | in_valid/in_ready/in_data | out_valid/out_ready/out_data,
//        out_remainder, out_divisible | bit_valid, bit_value (per-bit trace).
module serial_divisibility_word_checker
    import divisibility_pkg::*;
#(
    parameter  int W       = 8,
    parameter  int DIVISOR = 5,
    localparam int RW      = rem_width(DIVISOR)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [RW-1:0] out_remainder,
    output logic          out_divisible,
    output logic          bit_valid,
    output logic          bit_value
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    state_t        state;
    logic [W-1:0]  shreg;
    logic [W-1:0]  hold;
    logic [CW-1:0] cnt;
    logic [RW-1:0] rem;
    logic          accept;

    // in_ready is only ever high in IDLE, so this is the accept edge.
    assign accept = in_valid & in_ready;

    serial_mod_tracker #(
        .DIVISOR (DIVISOR)
    ) u_tracker (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .step   (bit_valid),
        .bit_in (shreg[W-1]),
        .rem    (rem)
    );

    // Handshake flags are registered alongside the state so every output is
    // a flop or a decode of flops; nothing depends on in_valid/out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            hold      <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            bit_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg     <= in_data;
                        hold      <= in_data;
                        cnt       <= CW'(W - 1);
                        state     <= SHIFT;
                        in_ready  <= 1'b0;
                        bit_valid <= 1'b1;
                    end
                end
                SHIFT: begin
                    shreg <= shreg << 1;
                    if (cnt == '0) begin
                        state     <= DONE;
                        bit_valid <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    bit_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_data      = hold;
    assign out_remainder = rem;
    assign out_divisible = (rem == '0);
    assign bit_value     = bit_valid & shreg[W-1];

endmodule

// File: tb/tb_serial_divisibility_word_checker.sv
// Testbench for serial_divisibility_word_checker: W=8/DIVISOR=5 and W=4/DIVISOR=3 instances.
// Reference results come from plain modulo arithmetic on each offered word.
// Ports of both instances are driven #1 after the rising edge and sampled there too.
module tb_serial_divisibility_word_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance A: W=8, DIVISOR=5
    logic       a_in_valid = 1'b0;
    logic       a_in_ready;
    logic [7:0] a_in_data = 8'h00;
    logic       a_out_valid;
    logic       a_out_ready = 1'b0;
    logic [7:0] a_out_data;
    logic [2:0] a_out_remainder;
    logic       a_out_divisible;
    logic       a_bit_valid;
    logic       a_bit_value;

    // Instance B: W=4, DIVISOR=3
    logic       b_in_valid = 1'b0;
    logic       b_in_ready;
    logic [3:0] b_in_data = 4'h0;
    logic       b_out_valid;
    logic       b_out_ready = 1'b0;
    logic [3:0] b_out_data;
    logic [1:0] b_out_remainder;
    logic       b_out_divisible;
    logic       b_bit_valid;
    logic       b_bit_value;

    serial_divisibility_word_checker #(.W(8), .DIVISOR(5)) dut_a (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (a_in_valid),
        .in_ready      (a_in_ready),
        .in_data       (a_in_data),
        .out_valid     (a_out_valid),
        .out_ready     (a_out_ready),
        .out_data      (a_out_data),
        .out_remainder (a_out_remainder),
        .out_divisible (a_out_divisible),
        .bit_valid     (a_bit_valid),
        .bit_value     (a_bit_value)
    );

    serial_divisibility_word_checker #(.W(4), .DIVISOR(3)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (b_in_valid),
        .in_ready      (b_in_ready),
        .in_data       (b_in_data),
        .out_valid     (b_out_valid),
        .out_ready     (b_out_ready),
        .out_data      (b_out_data),
        .out_remainder (b_out_remainder),
        .out_divisible (b_out_divisible),
        .bit_valid     (b_bit_valid),
        .bit_value     (b_bit_value)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one word through instance A and reports what was observed.
    task automatic run_a(input logic [7:0] w, input int hold, input bit scramble,
                         output int lat, output logic [7:0] bits, output logic [7:0] od,
                         output logic [2:0] orr, output logic odv, output int unstable,
                         output int rdy_bad, output bit done_ok);
        int guard;
        guard = 0;
        while (!a_in_ready && guard < 50) begin
            tick();
            guard++;
        end
        a_in_data   = w;
        a_in_valid  = 1'b1;
        a_out_ready = (hold == 0);
        tick();
        a_in_valid = 1'b0;
        lat = 0;
        bits = 8'h00;
        unstable = 0;
        rdy_bad = 0;
        while (!a_out_valid && lat < 100) begin
            if (a_bit_valid) bits = {bits[6:0], a_bit_value};
            if (a_in_ready) rdy_bad++;
            if (scramble) a_in_data = 8'($urandom);
            tick();
            lat++;
        end
        od  = a_out_data;
        orr = a_out_remainder;
        odv = a_out_divisible;
        for (int i = 0; i < hold; i++) begin
            if (scramble) a_in_data = 8'($urandom);
            if (a_in_ready) rdy_bad++;
            if (!a_out_valid || a_out_data !== od || a_out_remainder !== orr ||
                a_out_divisible !== odv) unstable++;
            tick();
        end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        done_ok = (a_out_valid === 1'b0) && (a_in_ready === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        tests++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_data !== 8'h00 ||
            a_out_remainder !== 3'd0 || a_out_divisible !== 1'b1 ||
            a_bit_valid !== 1'b0 || a_bit_value !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: rdy=%b vld=%b data=%h rem=%0d div=%b bv=%b bval=%b (need 1 0 00 0 1 0 0)",
                     a_in_ready, a_out_valid, a_out_data, a_out_remainder, a_out_divisible,
                     a_bit_valid, a_bit_value);
        end
        rst = 1'b0;
        tick();
        tests++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle: a_rdy=%b b_rdy=%b a_vld=%b (need 1 1 0)",
                     a_in_ready, b_in_ready, a_out_valid);
        end
    endtask

    task automatic test_single_word();
        int lat, unstable, rdy_bad;
        logic [7:0] bits, od;
        logic [2:0] orr;
        logic odv;
        bit done_ok;
        run_a(8'h0F, 0, 1'b0, lat, bits, od, orr, odv, unstable, rdy_bad, done_ok);
        tests++;
        if (lat !== 8) begin
            fails++;
            $display("FAIL single_latency: got %0d need 8", lat);
        end
        tests++;
        if (orr !== 3'd0 || odv !== 1'b1 || od !== 8'h0F) begin
            fails++;
            $display("FAIL single_result: rem=%0d div=%b data=%h need 0 1 0f", orr, odv, od);
        end
        tests++;
        if (bits !== 8'b0000_1111) begin
            fails++;
            $display("FAIL single_bits: got %b need 00001111", bits);
        end
        tests++;
        if (!done_ok || rdy_bad != 0) begin
            fails++;
            $display("FAIL single_handshake: done_ok=%0d rdy_bad=%0d need 1 0", done_ok, rdy_bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        int acc [3];
        logic [2:0] res_r [3];
        logic res_d [3];
        int n_acc, n_res;
        words[0] = 8'h07; words[1] = 8'hFF; words[2] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            acc[i] = 0; res_r[i] = 3'd7; res_d[i] = 1'bx;
        end
        n_acc = 0;
        n_res = 0;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = words[0];
        for (int c = 0; c < 80 && n_res < 3; c++) begin
            if (a_out_valid) begin
                res_r[n_res] = a_out_remainder;
                res_d[n_res] = a_out_divisible;
                n_res++;
            end
            if (a_in_ready && n_acc < 3) begin
                a_in_data = words[n_acc];
                acc[n_acc] = c;
                n_acc++;
            end else if (a_in_ready) begin
                a_in_valid = 1'b0;
            end
            tick();
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (res_r[i] !== 3'(words[i] % 8'd5) || res_d[i] !== (words[i] % 8'd5 == 0)) begin
                fails++;
                $display("FAIL b2b_result[%0d]: rem=%0d div=%b need %0d %b", i, res_r[i], res_d[i],
                         words[i] % 8'd5, (words[i] % 8'd5 == 0));
            end
        end
        for (int i = 1; i < 3; i++) begin
            tests++;
            if (acc[i] - acc[i-1] != 10) begin
                fails++;
                $display("FAIL b2b_spacing[%0d]: got %0d cycles need 10", i, acc[i] - acc[i-1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat, unstable, rdy_bad;
        logic [7:0] bits, od;
        logic [2:0] orr;
        logic odv;
        bit done_ok;
        run_a(8'h0D, 6, 1'b0, lat, bits, od, orr, odv, unstable, rdy_bad, done_ok);
        tests++;
        if (orr !== 3'd3 || odv !== 1'b0 || od !== 8'h0D) begin
            fails++;
            $display("FAIL bp_result: rem=%0d div=%b data=%h need 3 0 0d", orr, odv, od);
        end
        tests++;
        if (unstable != 0 || rdy_bad != 0) begin
            fails++;
            $display("FAIL bp_stable: unstable=%0d rdy_bad=%0d need 0 0", unstable, rdy_bad);
        end
        tests++;
        if (!done_ok) begin
            fails++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b need 0 1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_reset_midop();
        int seen, lat, unstable, rdy_bad;
        logic [7:0] bits, od;
        logic [2:0] orr;
        logic odv;
        bit done_ok;
        a_in_data  = 8'hAA;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_bit_valid !== 1'b0 ||
            a_out_data !== 8'h00 || a_out_remainder !== 3'd0 || a_out_divisible !== 1'b1) begin
            fails++;
            $display("FAIL midop_reset: rdy=%b vld=%b bv=%b data=%h rem=%0d div=%b need 1 0 0 00 0 1",
                     a_in_ready, a_out_valid, a_bit_valid, a_out_data, a_out_remainder, a_out_divisible);
        end
        seen = 0;
        repeat (20) begin
            if (a_out_valid) seen++;
            tick();
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL midop_no_result: out_valid cycles=%0d need 0", seen);
        end
        run_a(8'h19, 0, 1'b0, lat, bits, od, orr, odv, unstable, rdy_bad, done_ok);
        tests++;
        if (orr !== 3'd0 || odv !== 1'b1 || od !== 8'h19 || lat != 8) begin
            fails++;
            $display("FAIL midop_next_word: rem=%0d div=%b data=%h lat=%0d need 0 1 19 8", orr, odv, od, lat);
        end
    endtask

    task automatic test_sweep_w4();
        int lat, guard;
        for (int v = 0; v < 16; v++) begin
            guard = 0;
            while (!b_in_ready && guard < 50) begin
                tick();
                guard++;
            end
            b_in_data  = 4'(v);
            b_in_valid = 1'b1;
            tick();
            b_in_valid = 1'b0;
            b_in_data  = 4'(~v);
            lat = 0;
            while (!b_out_valid && lat < 100) begin
                tick();
                lat++;
            end
            tests++;
            if (b_out_remainder !== 2'(v % 3) || b_out_data !== 4'(v) || lat != 4) begin
                fails++;
                $display("FAIL sweep_rem[%0d]: rem=%0d data=%0d lat=%0d need %0d %0d 4",
                         v, b_out_remainder, b_out_data, lat, v % 3, v);
            end
            tests++;
            if (b_out_divisible !== (v % 3 == 0)) begin
                fails++;
                $display("FAIL sweep_div[%0d]: got %b need %b", v, b_out_divisible, (v % 3 == 0));
            end
            b_out_ready = 1'b1;
            tick();
            b_out_ready = 1'b0;
        end
    endtask

    task automatic test_input_stability();
        int lat, unstable, rdy_bad;
        logic [7:0] bits, od;
        logic [2:0] orr;
        logic odv;
        bit done_ok;
        run_a(8'h32, 3, 1'b1, lat, bits, od, orr, odv, unstable, rdy_bad, done_ok);
        tests++;
        if (od !== 8'h32 || orr !== 3'd0 || odv !== 1'b1 || bits !== 8'h32) begin
            fails++;
            $display("FAIL stability: data=%h rem=%0d div=%b bits=%h need 32 0 1 32", od, orr, odv, bits);
        end
        tests++;
        if (unstable != 0) begin
            fails++;
            $display("FAIL stability_hold: unstable=%0d need 0", unstable);
        end
    endtask

    task automatic test_random();
        int lat, unstable, rdy_bad;
        logic [7:0] w, bits, od;
        logic [2:0] orr;
        logic odv;
        bit done_ok;
        for (int n = 0; n < 24; n++) begin
            w = 8'($urandom);
            run_a(w, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                  lat, bits, od, orr, odv, unstable, rdy_bad, done_ok);
            tests++;
            if (orr !== 3'(w % 8'd5) || odv !== (w % 8'd5 == 0) || od !== w || bits !== w ||
                lat != 8 || unstable != 0 || !done_ok) begin
                fails++;
                $display("FAIL random[%0d] w=%h: rem=%0d div=%b data=%h bits=%h lat=%0d unst=%0d done=%0d need rem=%0d",
                         n, w, orr, odv, od, bits, lat, unstable, done_ok, w % 8'd5);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        test_sweep_w4();
        test_input_stability();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_divisibility_word_checker.md
# serial_divisibility_word_checker

Word-level front end for the serial divisibility datapath. It accepts a parallel W-bit word over a valid/ready handshake and streams it MSB-first through a serial remainder tracker, one bit per cycle. It then presents the word, its remainder modulo DIVISOR and a divisible flag over a second valid/ready handshake. It sits between a word producer and any consumer that needs per-word divisibility results.

## Interface
- W, default 8: word width; legal range 1 to 32.
- DIVISOR, default 5: modulus; legal range 2 to 255.
- RW, derived as $clog2(DIVISOR): remainder width; not overridable.

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  block can accept a word.
- in_data  input  W  word to check; bit W-1 is consumed first.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_data  output  W  copy of the accepted word.
- out_remainder  output  RW  accepted word mod DIVISOR.
- out_divisible  output  1  high when out_remainder == 0.
- bit_valid  output  1  high on every cycle a bit is consumed (SHIFT state).
- bit_value  output  1  the bit being consumed this cycle.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- IDLE:
  - in_ready = 1; all other handshake outputs are 0.
  - On in_valid & in_ready: load the shift register and the out_data hold register with in_data, clear the remainder to 0, load the bit counter with W-1, and go to SHIFT.
- SHIFT:
  - in_ready = 0; bit_valid = 1; bit_value = shift register MSB.
  - Each cycle: t = 2*rem + bit_value, computed in RW+1 bits. The new rem is t - DIVISOR when t >= DIVISOR, otherwise t.
  - The shift register shifts left by one, filling with 0. The counter decrements.
  - When the counter is 0 on a SHIFT cycle, that bit is the last one. Go to DONE.
- DONE:
  - out_valid = 1; out_remainder = rem; out_divisible = (rem == 0); out_data = held word.
  - All outputs stay stable while out_ready = 0, for any number of cycles.
  - On out_ready: go to IDLE.
- in_data is sampled only on the accept edge. Changes to in_data after that edge have no effect.
- in_valid in SHIFT or DONE is ignored and no word is lost. The producer keeps in_valid asserted until in_ready is high.
- out_ready outside DONE is ignored.
- Reset, including reset during SHIFT or DONE:
  - Next state is IDLE, with rem = 0, counter = 0, shift register = 0 and hold register = 0.
  - Reset values: in_ready = 1, out_valid = 0, out_data = 0, out_remainder = 0, out_divisible = 1, bit_valid = 0, bit_value = 0.
  - Any in-flight word is discarded and produces no output.

## Timing
- Let the accept edge be edge k.
- SHIFT occupies the W cycles after edges k through k+W-1.
- out_valid is first high in the cycle after edge k+W.
- Best-case throughput is one word per W+2 cycles: one DONE cycle with out_ready = 1 and one IDLE cycle. There is no IDLE bypass.
- bit_value in SHIFT cycle i (i = 0..W-1) equals in_data[W-1-i].
- All outputs are registered or decoded from state only. There is no combinational path from in_valid or out_ready to any output.

## Structure
- Package divisibility_pkg holds the state typedef (enum logic [1:0]: IDLE, SHIFT, DONE) and a function that returns the remainder width for a given divisor.
- Sub-module serial_mod_tracker (parameter DIVISOR):
  - Inputs: clk, rst, clear, step, bit_in.
  - Output: rem [RW-1:0].
  - It performs the remainder update above.
- The top-level module contains the handshake FSM, the bit counter, the shift register and the hold register.

## Test plan
1. W=8, DIVISOR=5: in_data = 0x0F, out_ready held high. Required: out_valid exactly 8 cycles after the accept edge, with out_remainder = 0, out_divisible = 1 and out_data = 0x0F. bit_value sequence = 0,0,0,0,1,1,1,1.
2. W=8, DIVISOR=5: back-to-back words 0x07, 0xFF, 0x00, with in_valid held high throughout. Required results in order: remainder 2 / divisible 0, remainder 0 / divisible 1, remainder 0 / divisible 1. Required spacing: 10 cycles between accept edges.
3. Backpressure: word 0x0D (13) with out_ready low for 6 cycles after out_valid rises. Required: out_remainder = 3 and out_divisible = 0, held stable; in_ready = 0 throughout; the result completes on the first out_ready cycle.
4. Reset mid-operation: assert rst in SHIFT cycle 3 of word 0xAA. Required: the next cycle shows IDLE with in_ready = 1 and out_valid = 0. A subsequent word 0x19 (25) yields remainder 0. No result is ever produced for 0xAA.
5. W=4, DIVISOR=3: sweep in_data from 0 to 15. Required: out_remainder == in_data % 3 for every value, and out_divisible high exactly for 0, 3, 6, 9, 12 and 15.
6. Input stability: change in_data on every cycle during SHIFT and DONE of word 0x32 (50), W=8, DIVISOR=5. Required: out_data = 0x32 and out_remainder = 0.
